// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control FSM and its ALU decoder.
// MC_JUMP_EN adds the JUMP state to the state enum.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_ADDIEXEC = 4'd8,
        S_ADDIWB   = 4'd9,
`ifdef MC_JUMP_EN
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
`else
        S_BRANCH   = 4'd10
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode: ALUOp plus the R-type funct field give ALUControl.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [3:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FUNCT_ADD: ALUControl = ALU_ADD;
                    FUNCT_SUB: ALUControl = ALU_SUB;
                    FUNCT_AND: ALUControl = ALU_AND;
                    FUNCT_OR:  ALUControl = ALU_OR;
                    FUNCT_SLT: ALUControl = ALU_SLT;
                    default:   ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle datapath; outputs decode from state only, except PCEn.
// Define MC_JUMP_EN to build the JUMP state; otherwise j is treated as an unsupported opcode.
module multicycle_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] ALUControl
);

    state_t     state_q;
    state_t     state_d;

    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        IorD          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        reg_write_raw = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_B;
        PCSrc         = PCSRC_ALU;
        pc_write      = 1'b0;
        branch        = 1'b0;
        alu_op        = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB      = SRCB_FOUR;
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
            end
            S_DECODE: ALUSrcB = SRCB_IMMSH;
            S_MEMADR, S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_ADDIWB: reg_write_raw = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Write enables are gated by reset so nothing commits while the FSM is held in FETCH.
    assign MemWrite = mem_write_raw & ~reset;
    assign IRWrite  = ir_write_raw & ~reset;
    assign RegWrite = reg_write_raw & ~reset;
    assign PCEn     = (pc_write | (branch & Zero)) & ~reset;

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .Funct      (Funct),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues expected outputs per cycle, a monitor compares.
// Honours MC_JUMP_EN to pick the expected behaviour of j.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUControl;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .ALUControl (ALUControl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector layout: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB PCSrc PCEn ALUControl
    function automatic logic [15:0] mk(input bit iord, input bit mw, input bit irw, input bit rd,
                                       input bit m2r, input bit rw, input bit sa, input logic [1:0] sb,
                                       input logic [1:0] pcs, input bit pcen, input logic [3:0] alu);
        return {iord, mw, irw, rd, m2r, rw, sa, sb, pcs, pcen, alu};
    endfunction

    function automatic logic [15:0] v_fetch();  return mk(0,0,1,0,0,0,0,2'b01,2'b00,1,4'b0010); endfunction
    function automatic logic [15:0] v_rst();    return mk(0,0,0,0,0,0,0,2'b01,2'b00,0,4'b0010); endfunction
    function automatic logic [15:0] v_dec();    return mk(0,0,0,0,0,0,0,2'b11,2'b00,0,4'b0010); endfunction
    function automatic logic [15:0] v_adr();    return mk(0,0,0,0,0,0,1,2'b10,2'b00,0,4'b0010); endfunction
    function automatic logic [15:0] v_memrd();  return mk(1,0,0,0,0,0,0,2'b00,2'b00,0,4'b0010); endfunction
    function automatic logic [15:0] v_memwb();  return mk(0,0,0,0,1,1,0,2'b00,2'b00,0,4'b0010); endfunction
    function automatic logic [15:0] v_memwr();  return mk(1,1,0,0,0,0,0,2'b00,2'b00,0,4'b0010); endfunction
    function automatic logic [15:0] v_exec(input logic [3:0] a);
        return mk(0,0,0,0,0,0,1,2'b00,2'b00,0,a);
    endfunction
    function automatic logic [15:0] v_aluwb();  return mk(0,0,0,1,0,1,0,2'b00,2'b00,0,4'b0010); endfunction
    function automatic logic [15:0] v_addiwb(); return mk(0,0,0,0,0,1,0,2'b00,2'b00,0,4'b0010); endfunction
    function automatic logic [15:0] v_br(input bit z);
        return mk(0,0,0,0,0,0,1,2'b00,2'b01,z,4'b0110);
    endfunction
    function automatic logic [15:0] v_jump();   return mk(0,0,0,0,0,0,0,2'b00,2'b10,1,4'b0010); endfunction

    // One clock cycle of stimulus: drive inputs shortly after the edge, queue that cycle's expectation.
    task automatic cyc(input bit rst, input logic [5:0] op, input logic [5:0] fn, input bit z,
                       input logic [15:0] e, input string nm);
        @(posedge clk);
        #1;
        reset = rst;
        Op    = op;
        Funct = fn;
        Zero  = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [15:0] got;
        logic [15:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                       ALUSrcB, PCSrc, PCEn, ALUControl};
                tests_run++;
                if (got !== e) begin
                    tests_failed++;
                    $display("FAIL %s: got %b required %b (IorD MW IRW RD M2R RW SA SB PCS PCEn ALUC)",
                             nm, got, e);
                end else begin
                    $display("[TB] ok %s = %b", nm, got);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JOP = 6'b000010, BAD = 6'b111111;

    initial begin : stimulus
        logic [5:0] fns [5];
        logic [3:0] alus[5];
        fns[0] = 6'b100000; alus[0] = 4'b0010;
        fns[1] = 6'b100010; alus[1] = 4'b0110;
        fns[2] = 6'b100100; alus[2] = 4'b0000;
        fns[3] = 6'b100101; alus[3] = 4'b0001;
        fns[4] = 6'b101010; alus[4] = 4'b0111;

        reset = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;

        cyc(1, RT, 6'd0, 0, v_rst(), "reset_hold0");
        cyc(1, RT, 6'd0, 1, v_rst(), "reset_hold1_zero");
        cyc(0, LW, 6'd0, 0, v_fetch(), "first_fetch");

        // lw: 5 cycles
        cyc(0, LW, 6'd0, 1, v_dec(), "lw_decode");
        cyc(0, LW, 6'd0, 1, v_adr(), "lw_memadr");
        cyc(0, LW, 6'd0, 0, v_memrd(), "lw_memrd");
        cyc(0, LW, 6'd0, 0, v_memwb(), "lw_memwb");

        // R-type, every funct
        for (int i = 0; i < 5; i++) begin
            cyc(0, RT, fns[i], 0, v_fetch(), $sformatf("rt%0d_fetch", i));
            cyc(0, RT, fns[i], 0, v_dec(), $sformatf("rt%0d_decode", i));
            cyc(0, RT, fns[i], 1, v_exec(alus[i]), $sformatf("rt%0d_execute", i));
            cyc(0, RT, fns[i], 0, v_aluwb(), $sformatf("rt%0d_aluwb", i));
        end

        // beq taken, then not taken
        cyc(0, BEQ, 6'd0, 1, v_fetch(), "beq_t_fetch");
        cyc(0, BEQ, 6'd0, 1, v_dec(), "beq_t_decode");
        cyc(0, BEQ, 6'd0, 1, v_br(1), "beq_t_branch");
        cyc(0, BEQ, 6'd0, 0, v_fetch(), "beq_n_fetch");
        cyc(0, BEQ, 6'd0, 0, v_dec(), "beq_n_decode");
        cyc(0, BEQ, 6'd0, 0, v_br(0), "beq_n_branch");

        // sw then addi back-to-back
        cyc(0, SW, 6'd0, 0, v_fetch(), "sw_fetch");
        cyc(0, SW, 6'd0, 0, v_dec(), "sw_decode");
        cyc(0, SW, 6'd0, 0, v_adr(), "sw_memadr");
        cyc(0, SW, 6'd0, 0, v_memwr(), "sw_memwr");
        cyc(0, ADDI, 6'd0, 0, v_fetch(), "addi_fetch");
        cyc(0, ADDI, 6'd0, 0, v_dec(), "addi_decode");
        cyc(0, ADDI, 6'd0, 0, v_adr(), "addi_exec");
        cyc(0, ADDI, 6'd0, 0, v_addiwb(), "addi_wb");

        // unsupported opcode: 2 cycles
        cyc(0, BAD, 6'd0, 1, v_fetch(), "bad_fetch");
        cyc(0, BAD, 6'd0, 1, v_dec(), "bad_decode");

        // j
        cyc(0, JOP, 6'd0, 0, v_fetch(), "j_fetch");
        cyc(0, JOP, 6'd0, 0, v_dec(), "j_decode");
`ifdef MC_JUMP_EN
        cyc(0, JOP, 6'd0, 0, v_jump(), "j_jump");
`endif

        // lw interrupted by reset in MEMWB
        cyc(0, LW, 6'd0, 0, v_fetch(), "lw2_fetch");
        cyc(0, LW, 6'd0, 0, v_dec(), "lw2_decode");
        cyc(0, LW, 6'd0, 0, v_adr(), "lw2_memadr");
        cyc(0, LW, 6'd0, 0, v_memrd(), "lw2_memrd");
        cyc(1, LW, 6'd0, 0, v_rst(), "lw2_reset_in_memwb");
        cyc(0, RT, 6'b100010, 0, v_fetch(), "post_reset_fetch");
        cyc(0, RT, 6'b100010, 0, v_dec(), "post_reset_decode");
        cyc(0, RT, 6'b100010, 0, v_exec(4'b0110), "post_reset_execute");
        cyc(0, RT, 6'b100010, 0, v_aluwb(), "post_reset_aluwb");
        cyc(0, RT, 6'b100010, 0, v_fetch(), "final_fetch");

        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle 32-bit datapath. It sits directly upstream of the ALU and drives its 4-bit ALUControl input along with every datapath mux select and write enable. Each cycle it decodes opcode and funct from the instruction register. It consumes the ALU's Zero flag to resolve beq.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces the FSM to FETCH
- Op  in  6  instruction[31:26] from the instruction register
- Funct  in  6  instruction[5:0]
- Zero  in  1  ALU Zero flag, same cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register load enable
- RegDst  out  1  destination register select: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = Data
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A source: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B source: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load enable
- ALUControl  out  4  ALU operation code

## Operation
- Moore FSM with a one-hot or binary state register, team's choice. Outputs are decoded combinationally from the state only. PCEn is the one exception: PCEn = PCWrite | (Branch & Zero).
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- Transitions:
  - FETCH → DECODE.
  - DECODE branches on Op: lw/sw → MEMADR; R-type → EXECUTE; beq → BRANCH; addi → ADDIEXEC; j → JUMP. Any other opcode → FETCH, with no write enable asserted.
  - MEMADR → MEMRD for lw, or → MEMWR for sw.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECUTE → ALUWB → FETCH.
  - ADDIEXEC → ADDIWB → FETCH.
  - BRANCH → FETCH.
  - JUMP → FETCH.
- Per-state outputs. Every signal not listed is 0; ALUOp defaults to 00.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - JUMP: PCSrc=10, PCWrite=1.
- ALU decode:
  - ALUOp 00 → 0010 (add).
  - ALUOp 01 → 0110 (sub).
  - ALUOp 10 → decode Funct:
    - 100000 → 0010 (add)
    - 100010 → 0110 (sub)
    - 100100 → 0000 (and)
    - 100101 → 0001 (or)
    - 101010 → 0111 (slt)
    - any other Funct → 0010.

## Timing
- Reset:
  - State is FETCH asynchronously on assertion.
  - While reset is high, PCEn, IRWrite, RegWrite and MemWrite are forced to 0.
  - The other outputs carry FETCH values, so ALUControl=0010.
  - The first clock edge after deassertion executes FETCH.
- Reset mid-instruction abandons the instruction immediately; no partial write occurs after assertion.
- Latency from the FETCH cycle to return to FETCH:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - unsupported opcode: 2 cycles
- Branch resolution: Zero is sampled combinationally in BRANCH only. Zero in any other state has no effect on PCEn.
- Op and Funct must be stable from DECODE until return to FETCH. IRWrite is asserted only in FETCH, which guarantees this.

## Configuration
- MC_JUMP_EN:
  - Defined: the JUMP state exists and j follows DECODE → JUMP → FETCH with PCEn=1 and PCSrc=10.
  - Undefined: the JUMP state is not compiled. j is treated as an unsupported opcode (DECODE → FETCH, no PC load), and PCSrc never takes value 10.

## Structure
- Package mc_pkg holds:
  - the state enum
  - the opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - the funct localparams
  - the ALUControl localparams (ALU_ADD=0010, ALU_SUB=0110, ALU_AND=0000, ALU_OR=0001, ALU_SLT=0111)
  - the 2-bit ALUOp encodings.
- Sub-module alu_decoder (combinational, ALUOp + Funct → ALUControl) is instantiated once.
- The FSM next-state and output logic stays in multicycle_control.

## Test plan
- Reset asserted mid-MEMWB:
  - State returns to FETCH without waiting for a clock edge.
  - RegWrite=0 and PCEn=0 while reset is high.
  - After release, the first cycle shows IRWrite=1, PCEn=1, ALUControl=0010.
- lw (Op=100011): visits FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. MEMWB has RegWrite=1 and MemtoReg=1; MEMRD has IorD=1.
- R-type with each Funct (100000/100010/100100/100101/101010):
  - In EXECUTE, ALUControl = 0010/0110/0000/0001/0111 respectively.
  - ALUWB has RegDst=1 and RegWrite=1.
- beq: BRANCH with Zero=1 gives PCEn=1, PCSrc=01, ALUControl=0110; with Zero=0, PCEn=0. Both cases return to FETCH next cycle.
- sw then addi back-to-back:
  - sw asserts MemWrite=1 only in its 4th cycle.
  - addi gives ADDIWB RegWrite=1, RegDst=0 in its 4th cycle.
- Opcode 111111, and j with MC_JUMP_EN undefined: DECODE → FETCH with no write enable asserted. With MC_JUMP_EN defined, j gives PCSrc=10, PCEn=1 in its 3rd cycle.
